// File: rtl/puf_resp_evaluator_if.sv
// Request/response and latch-control bundle for puf_resp_evaluator.
// master: requester / latch side.  slave: the evaluator.
interface puf_resp_evaluator_if #(
  parameter int unsigned NUM_EVAL = 15
);
  localparam int unsigned CNT_W = $clog2(NUM_EVAL + 1);

  logic             start;
  logic             arb_clr;
  logic             race_go;
  logic             cap_en;
  logic             cap_bit;
  logic             busy;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp;
  logic             stable;
  logic [CNT_W-1:0] ones_cnt;

  modport master (
    output start, cap_bit, resp_ready,
    input  arb_clr, race_go, cap_en, busy, resp_valid, resp, stable, ones_cnt
  );

  modport slave (
    input  start, cap_bit, resp_ready,
    output arb_clr, race_go, cap_en, busy, resp_valid, resp, stable, ones_cnt
  );
endinterface

// File: rtl/puf_resp_evaluator.sv
// PUF response evaluator: repeats one arbiter race NUM_EVAL times per
// request (clear, launch, settle, capture, sample), then presents the
// majority bit, a stability flag and the count of ones.
// Optional macro PUF_EVAL_EARLY_EXIT_EN: finish as soon as the outcome
// (stable or unstable) can no longer change.
module puf_resp_evaluator #(
  parameter int unsigned NUM_EVAL   = 15,
  parameter int unsigned THRESH     = 13,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic                    clk,
  input logic                    rst,
  puf_resp_evaluator_if.slave    bus
);
  localparam int unsigned CNT_W = $clog2(NUM_EVAL + 1);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_EVAL);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESH);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FIRE, S_SETTLE, S_CAPTURE, S_SAMPLE, S_DONE
  } state_t;

  state_t           state_q;
  logic [SET_W-1:0] settle_q;
  logic [CNT_W-1:0] ones_q, idx_q;
  logic             arb_clr_q, race_go_q, cap_en_q, busy_q;
  logic             resp_valid_q, resp_q, stable_q;

  logic [CNT_W-1:0] ones_d, idx_d, zeros_d;
  logic             resp_d, stable_d, finish_d;

  // Counts after the current SAMPLE, and the resulting decision.
  always_comb begin
    ones_d   = ones_q + CNT_W'(bus.cap_bit);
    idx_d    = idx_q + CNT_W'(1);
    zeros_d  = idx_d - ones_d;
    resp_d   = (ones_d > zeros_d);
    stable_d = (ones_d >= THR_C) || (zeros_d >= THR_C);
    finish_d = (idx_d == NUM_C);
`ifdef PUF_EVAL_EARLY_EXIT_EN
    // Stop once neither value can reach THRESH with the remaining races,
    // or one already has; ones+rem never exceeds NUM_EVAL so no overflow.
    begin
      logic [CNT_W-1:0] rem;
      rem = NUM_C - idx_d;
      if (stable_d || (((ones_d + rem) < THR_C) && ((zeros_d + rem) < THR_C)))
        finish_d = 1'b1;
    end
`endif
  end

  // Sequencer: state, counters and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      ones_q       <= '0;
      idx_q        <= '0;
      arb_clr_q    <= 1'b0;
      race_go_q    <= 1'b0;
      cap_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      stable_q     <= 1'b0;
    end else begin
      arb_clr_q <= 1'b0;
      race_go_q <= 1'b0;
      cap_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_CLEAR;
            arb_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            ones_q    <= '0;
            idx_q     <= '0;
          end
        end
        S_CLEAR: begin
          state_q   <= S_FIRE;
          race_go_q <= 1'b1;
        end
        S_FIRE: begin
          state_q  <= S_SETTLE;
          settle_q <= '0;
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_q  <= S_CAPTURE;
            cap_en_q <= 1'b1;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        S_CAPTURE: begin
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          ones_q <= ones_d;
          idx_q  <= idx_d;
          if (finish_d) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_q       <= resp_d;
            stable_q     <= stable_d;
          end else begin
            state_q   <= S_CLEAR;
            arb_clr_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            stable_q     <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.arb_clr    = arb_clr_q;
  assign bus.race_go    = race_go_q;
  assign bus.cap_en     = cap_en_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp       = resp_q;
  assign bus.stable     = stable_q;
  assign bus.ones_cnt   = ones_q;
endmodule
